// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART receiver that packs bytes into little-endian 32-bit program words
// Optional even-parity framing (8E1) is enabled by defining UART_PARITY_EN.
module uart_program_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_rx,
   output logic        data_valid,
   output logic [31:0] data_out,
   output logic [31:0] byte_address,
   output logic        frame_error,
   output logic        busy
);

   localparam logic [15:0] HALF_BIT     = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] FULL_BIT     = 16'(CLKS_PER_BIT - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic [1:0]  byte_idx;
   logic [23:0] word_buf;
   logic [31:0] addr_cnt;
   logic [31:0] timeout_cnt;
   logic        stop_wait;
`ifdef UART_PARITY_EN
   logic        parity_bad;
`endif

   assign busy = (state != IDLE) || (byte_idx != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         rx_prev      <= 1'b1;
         bit_cnt      <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         byte_idx     <= '0;
         word_buf     <= '0;
         addr_cnt     <= '0;
         timeout_cnt  <= '0;
         stop_wait    <= 1'b0;
         data_valid   <= 1'b0;
         data_out     <= '0;
         byte_address <= '0;
         frame_error  <= 1'b0;
`ifdef UART_PARITY_EN
         parity_bad   <= 1'b0;
`endif
      end else begin
         rx_meta     <= io_rx;
         rx_sync     <= rx_meta;
         rx_prev     <= rx_sync;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;

         // A partial word left idle too long is dropped; leaving IDLE restarts the count
         if (state == IDLE && byte_idx != 2'd0) begin
            if (timeout_cnt == TIMEOUT_LAST) begin
               byte_idx    <= 2'd0;
               timeout_cnt <= '0;
            end else begin
               timeout_cnt <= timeout_cnt + 32'd1;
            end
         end else begin
            timeout_cnt <= '0;
         end

         case (state)
            IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state   <= START;
                  bit_cnt <= HALF_BIT;
               end
            end
            START: begin
               if (bit_cnt != 16'd0) begin
                  bit_cnt <= bit_cnt - 16'd1;
               end else if (!rx_sync) begin
                  state   <= DATA;
                  bit_cnt <= FULL_BIT;
                  bit_idx <= 3'd0;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (bit_cnt != 16'd0) begin
                  bit_cnt <= bit_cnt - 16'd1;
               end else begin
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  bit_cnt   <= FULL_BIT;
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (bit_cnt != 16'd0) begin
                  bit_cnt <= bit_cnt - 16'd1;
               end else begin
                  parity_bad <= ^{shift_reg, rx_sync};
                  bit_cnt    <= FULL_BIT;
                  state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (stop_wait) begin
                  // Bad stop bit: hold here until the line returns high
                  if (rx_sync) begin
                     stop_wait <= 1'b0;
                     state     <= IDLE;
                  end
               end else if (bit_cnt != 16'd0) begin
                  bit_cnt <= bit_cnt - 16'd1;
               end else if (!rx_sync) begin
                  frame_error <= 1'b1;
                  stop_wait   <= 1'b1;
               end else
`ifdef UART_PARITY_EN
               if (parity_bad) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
               end else
`endif
               begin
                  state    <= IDLE;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= shift_reg;
                     2'd1: word_buf[15:8]  <= shift_reg;
                     2'd2: word_buf[23:16] <= shift_reg;
                     2'd3: begin
                        data_out     <= {shift_reg, word_buf};
                        data_valid   <= 1'b1;
                        byte_address <= addr_cnt;
                        addr_cnt     <= addr_cnt + 32'd4;
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - directed bench for uart_program_loader at 16 clocks per bit
module tb_uart_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        io_rx = 1'b1;
   logic        data_valid;
   logic [31:0] data_out;
   logic [31:0] byte_address;
   logic        frame_error;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int vcount = 0;
   int fecount = 0;
   logic [31:0] logd [16];
   logic [31:0] loga [16];

   uart_program_loader #(.CLKS_PER_BIT(16), .TIMEOUT_BITS(32)) dut (
      .clk(clk),
      .reset(reset),
      .io_rx(io_rx),
      .data_valid(data_valid),
      .data_out(data_out),
      .byte_address(byte_address),
      .frame_error(frame_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Counts cycles each pulse is high, so a word or error that is not a single-cycle pulse is visible
   always @(negedge clk) begin
      if (data_valid === 1'b1 && vcount < 16) begin
         logd[vcount] <= data_out;
         loga[vcount] <= byte_address;
         vcount <= vcount + 1;
      end
      if (frame_error === 1'b1)
         fecount <= fecount + 1;
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic bit_time();
      repeat (16) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
      @(negedge clk);
      io_rx = 1'b0;
      bit_time();
      for (int i = 0; i < 8; i++) begin
         io_rx = d[i];
         bit_time();
      end
`ifdef UART_PARITY_EN
      io_rx = (^d) ^ par_flip;
      bit_time();
`endif
      io_rx = stop;
      bit_time();
      io_rx = 1'b1;
      if (!stop)
         repeat (32) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_frame(d, 1'b1, 1'b0);
   endtask

   initial begin
      wait_cycles(3);
      check("rst_data_valid", {31'd0, data_valid}, 32'd0);
      check("rst_data_out", data_out, 32'h0);
      check("rst_byte_address", byte_address, 32'h0);
      check("rst_frame_error", {31'd0, frame_error}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      wait_cycles(20);

      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      wait_cycles(4);
      check("w0_count", vcount, 32'd1);
      check("w0_data", logd[0], 32'h00000013);
      check("w0_addr", loga[0], 32'h00000000);
      check("w0_busy", {31'd0, busy}, 32'd0);
      wait_cycles(50);
      check("w0_hold_data", data_out, 32'h00000013);
      check("w0_hold_addr", byte_address, 32'h00000000);

      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      send_byte(8'h11); send_byte(8'h11); send_byte(8'h00); send_byte(8'h00);
      wait_cycles(4);
      check("w12_count", vcount, 32'd3);
      check("w1_data", logd[1], 32'hDEADBEEF);
      check("w1_addr", loga[1], 32'h00000004);
      check("w2_data", logd[2], 32'h00001111);
      check("w2_addr", loga[2], 32'h00000008);
      check("w2_fe_none", fecount, 32'd0);

      send_frame(8'h55, 1'b0, 1'b0);
      wait_cycles(4);
      check("fe_count", fecount, 32'd1);
      check("fe_no_word", vcount, 32'd3);
      check("fe_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_cycles(4);
      check("w3_count", vcount, 32'd4);
      check("w3_data", logd[3], 32'h04030201);
      check("w3_addr", loga[3], 32'h0000000C);

      @(negedge clk);
      io_rx = 1'b0;
      repeat (5) @(negedge clk);
      io_rx = 1'b1;
      wait_cycles(30);
      check("glitch_busy", {31'd0, busy}, 32'd0);
      check("glitch_fe", fecount, 32'd1);
      check("glitch_words", vcount, 32'd4);

      send_byte(8'hAA); send_byte(8'hBB);
      wait_cycles(4);
      check("partial_busy", {31'd0, busy}, 32'd1);
      wait_cycles(33 * 16 - 4);
      check("timeout_busy", {31'd0, busy}, 32'd0);
      check("timeout_fe", fecount, 32'd1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_cycles(4);
      check("w4_count", vcount, 32'd5);
      check("w4_data", logd[4], 32'h04030201);
      check("w4_addr", loga[4], 32'h00000010);

      send_byte(8'hAA);
      @(negedge clk);
      io_rx = 1'b0;
      repeat (16 * 4) @(negedge clk);
      #1;
      check("midframe_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      io_rx = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_data", data_out, 32'h0);
      check("abort_addr", byte_address, 32'h0);
      check("abort_words", vcount, 32'd5);
      check("abort_fe", fecount, 32'd1);
      wait_cycles(20);
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
      wait_cycles(4);
      check("w5_count", vcount, 32'd6);
      check("w5_data", logd[5], 32'hD4C3B2A1);
      check("w5_addr", loga[5], 32'h00000000);

`ifdef UART_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      wait_cycles(4);
      check("par_bad_fe", fecount, 32'd2);
      check("par_bad_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h07); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      wait_cycles(4);
      check("par_count", vcount, 32'd7);
      check("par_data", logd[6], 32'h00000007);
      check("par_addr", loga[6], 32'h00000004);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
